// File: rtl/cmp_mon_pkg.sv
// Shared definitions for cmp_event_monitor: FSM state encoding, class
// encoding constants for trend_dir, and the width helper for the run counter.
package cmp_mon_pkg;

  // Tracking FSM states; the encoding is visible on dbg_state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRK_GT = 2'd1,
    ST_TRK_LT = 2'd2,
    ST_TRK_EQ = 2'd3
  } mon_state_e;

  // Result class encoding as seen on trend_dir.
  localparam logic [1:0] DIR_EQ = 2'b00;
  localparam logic [1:0] DIR_GT = 2'b01;
  localparam logic [1:0] DIR_LT = 2'b10;

  // Bits needed for a run counter that must be able to hold streak_len.
  function automatic int run_w(input int streak_len);
    return $clog2(streak_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, holds at all-ones, synchronous
// clear has priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count up on inc until saturated; clr wins over inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != CNT_MAX)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cmp_event_monitor.sv
// Event monitor downstream of the 4-bit magnitude comparator. Classifies
// each valid greater/lesser result as GT/LT/EQ, keeps saturating per-class
// counts, and pulses trend_valid once when a run of identical classes reaches
// STREAK_LEN. Optional macro CMP_MON_ERR_EN: when defined, a sample with both
// greater and lesser high is flagged via sticky err and restarts tracking;
// when undefined such a sample counts as GT and err is tied low.
//
// Input handshake: cmp_valid alone qualifies greater/lesser in the cycle it
// is high; there is no ready, every valid sample is consumed on that edge.
module cmp_event_monitor
  import cmp_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int STREAK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cmp_valid,
  input  logic             greater,
  input  logic             lesser,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             trend_valid,
  output logic [1:0]       trend_dir,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int RUN_W = run_w(STREAK_LEN);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] TRK_GT = ST_TRK_GT;
  localparam logic [1:0] TRK_LT = ST_TRK_LT;
  localparam logic [1:0] TRK_EQ = ST_TRK_EQ;

  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(STREAK_LEN);
  localparam logic [RUN_W-1:0] RUN_PULSE = RUN_W'(STREAK_LEN - 1);

  logic             illegal;
  logic             is_gt;
  logic             is_lt;
  logic             is_eq;
  logic             legal;
  logic [1:0]       sample_dir;
  logic [1:0]       sample_state;
  logic [1:0]       state;
  logic [RUN_W-1:0] run;

`ifdef CMP_MON_ERR_EN
  assign illegal = cmp_valid & greater & lesser;
  assign is_gt   = greater & ~lesser;
`else
  // Both-high is folded into GT, so nothing is ever illegal.
  assign illegal = 1'b0;
  assign is_gt   = greater;
`endif
  assign is_lt = ~greater & lesser;
  assign is_eq = ~greater & ~lesser;
  assign legal = cmp_valid & ~illegal;

  // Map the current sample to its class code and tracking state.
  always_comb begin
    sample_dir   = DIR_EQ;
    sample_state = TRK_EQ;
    if (is_gt) begin
      sample_dir   = DIR_GT;
      sample_state = TRK_GT;
    end else if (is_lt) begin
      sample_dir   = DIR_LT;
      sample_state = TRK_LT;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (legal & is_gt),
    .q     (gt_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (legal & is_lt),
    .q     (lt_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (legal & is_eq),
    .q     (eq_cnt)
  );

  // Run tracking FSM; trend_valid fires only on the STREAK_LEN-1 -> STREAK_LEN
  // step, and run saturates so a continuing run never re-pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      run         <= '0;
      trend_valid <= 1'b0;
      trend_dir   <= DIR_EQ;
    end else if (clr) begin
      state       <= IDLE;
      run         <= '0;
      trend_valid <= 1'b0;
      trend_dir   <= DIR_EQ;
    end else begin
      trend_valid <= 1'b0;
      if (illegal) begin
        state     <= IDLE;
        run       <= '0;
        trend_dir <= DIR_EQ;
      end else if (cmp_valid) begin
        if (state == sample_state) begin
          if (run != RUN_MAX) begin
            run <= run + RUN_W'(1);
          end
          if (run == RUN_PULSE) begin
            trend_valid <= 1'b1;
          end
        end else begin
          state     <= sample_state;
          run       <= RUN_W'(1);
          trend_dir <= sample_dir;
        end
      end
    end
  end

`ifdef CMP_MON_ERR_EN
  // Sticky illegal-input flag, cleared only by clr or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if (illegal) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  assign dbg_state = state;

endmodule
